// File: rtl/operand_fetch_if.sv
// operand_fetch_if: instruction, operand, writeback and register-file signals of the operand-fetch stage
interface operand_fetch_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 5
);
    logic              in_valid;
    logic              in_ready;
    logic [ADDR_W-1:0] in_src1_addr;
    logic [ADDR_W-1:0] in_src2_addr;
    logic [ADDR_W-1:0] in_dst_addr;
    logic              in_dst_we;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_src1;
    logic [DATA_W-1:0] out_src2;
    logic [ADDR_W-1:0] out_dst_addr;
    logic              out_dst_we;
    logic              wb_valid;
    logic [ADDR_W-1:0] wb_addr;
    logic [DATA_W-1:0] wb_data;
    logic [ADDR_W-1:0] rf_src1_addr;
    logic [ADDR_W-1:0] rf_src2_addr;
    logic [DATA_W-1:0] rf_src1;
    logic [DATA_W-1:0] rf_src2;
    logic              rf_write;
    logic [ADDR_W-1:0] rf_dst_addr;
    logic [DATA_W-1:0] rf_dst;

    modport master (
        output in_valid, in_src1_addr, in_src2_addr, in_dst_addr, in_dst_we,
        output out_ready, wb_valid, wb_addr, wb_data, rf_src1, rf_src2,
        input  in_ready, out_valid, out_src1, out_src2, out_dst_addr, out_dst_we,
        input  rf_src1_addr, rf_src2_addr, rf_write, rf_dst_addr, rf_dst
    );

    modport slave (
        input  in_valid, in_src1_addr, in_src2_addr, in_dst_addr, in_dst_we,
        input  out_ready, wb_valid, wb_addr, wb_data, rf_src1, rf_src2,
        output in_ready, out_valid, out_src1, out_src2, out_dst_addr, out_dst_we,
        output rf_src1_addr, rf_src2_addr, rf_write, rf_dst_addr, rf_dst
    );
endinterface

// File: rtl/operand_fetch.sv
// operand_fetch: scoreboarded operand fetch that stalls on RAW/WAW hazards and owns the register file ports
module operand_fetch #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 5
) (
    input logic          clk,
    input logic          rst_n,
    operand_fetch_if.slave bus
);
    localparam int NREG = 1 << ADDR_W;

    typedef enum logic [2:0] {IDLE, WAIT, READ, CAPT, VALID} state_t;

    state_t            state_q, state_d;
    logic [NREG-1:0]   busy_q, busy_d;
    logic [ADDR_W-1:0] src1_q, src1_d;
    logic [ADDR_W-1:0] src2_q, src2_d;
    logic [ADDR_W-1:0] dst_q, dst_d;
    logic              dst_we_q, dst_we_d;
    logic [DATA_W-1:0] op1_q, op1_d;
    logic [DATA_W-1:0] op2_q, op2_d;
    logic              hazard;

    assign hazard = busy_q[src1_q] | busy_q[src2_q] | (dst_we_q & busy_q[dst_q]);

    assign bus.in_ready     = rst_n & (state_q == IDLE);
    assign bus.out_valid    = rst_n & (state_q == VALID);
    assign bus.out_src1     = op1_q;
    assign bus.out_src2     = op2_q;
    assign bus.out_dst_addr = dst_q;
    assign bus.out_dst_we   = dst_we_q;
    assign bus.rf_src1_addr = src1_q;
    assign bus.rf_src2_addr = src2_q;
    assign bus.rf_write     = bus.wb_valid & rst_n;
    assign bus.rf_dst_addr  = bus.wb_addr;
    assign bus.rf_dst       = bus.wb_data;

    // Next state: writeback clears first so an issue to the same register on the same edge wins
    always_comb begin
        state_d  = state_q;
        busy_d   = busy_q;
        src1_d   = src1_q;
        src2_d   = src2_q;
        dst_d    = dst_q;
        dst_we_d = dst_we_q;
        op1_d    = op1_q;
        op2_d    = op2_q;
        if (bus.wb_valid) busy_d[bus.wb_addr] = 1'b0;
        case (state_q)
            IDLE: if (bus.in_valid) begin
                src1_d   = bus.in_src1_addr;
                src2_d   = bus.in_src2_addr;
                dst_d    = bus.in_dst_addr;
                dst_we_d = bus.in_dst_we;
                state_d  = WAIT;
            end
            WAIT: state_d = hazard ? WAIT : READ;
            READ: state_d = CAPT;
            CAPT: begin
                op1_d   = bus.rf_src1;
                op2_d   = bus.rf_src2;
                state_d = VALID;
            end
            VALID: if (bus.out_ready) begin
                if (dst_we_q) busy_d[dst_q] = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and scoreboard registers; reset drops any held instruction
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            busy_q   <= '0;
            src1_q   <= '0;
            src2_q   <= '0;
            dst_q    <= '0;
            dst_we_q <= 1'b0;
            op1_q    <= '0;
            op2_q    <= '0;
        end else begin
            state_q  <= state_d;
            busy_q   <= busy_d;
            src1_q   <= src1_d;
            src2_q   <= src2_d;
            dst_q    <= dst_d;
            dst_we_q <= dst_we_d;
            op1_q    <= op1_d;
            op2_q    <= op2_d;
        end
    end
endmodule

// File: tb/tb_operand_fetch.sv
// tb_operand_fetch: directed and randomized checks of operand_fetch against a scoreboard/register-file model
module tb_operand_fetch;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int nchecks = 0;
    int nerr = 0;

    logic [15:0] m_mem [32];
    logic [31:0] m_busy = '0;
    logic [4:0]  last_dst = '0;
    logic        last_we = 1'b0;

    logic [15:0] rf_mem [32];

    operand_fetch_if bus ();

    operand_fetch dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    // Register file stand-in: registered reads, one-cycle latency
    always @(posedge clk) begin
        if (bus.rf_write) rf_mem[bus.rf_dst_addr] <= bus.rf_dst;
        bus.rf_src1 <= rf_mem[bus.rf_src1_addr];
        bus.rf_src2 <= rf_mem[bus.rf_src2_addr];
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wb(input logic [4:0] a, input logic [15:0] d);
        bus.wb_valid = 1'b1;
        bus.wb_addr  = a;
        bus.wb_data  = d;
        step();
        bus.wb_valid = 1'b0;
        m_mem[a]  = d;
        m_busy[a] = 1'b0;
    endtask

    task automatic issue(input logic [4:0] s1, input logic [4:0] s2, input logic [4:0] d, input logic we);
        int n = 0;
        while (!bus.in_ready && n < 20) begin
            step();
            n++;
        end
        nchecks++;
        if (!bus.in_ready) begin
            nerr++;
            $display("FAIL issue_ready in_ready=%0b after %0d cycles, want 1", bus.in_ready, n);
        end
        bus.in_valid     = 1'b1;
        bus.in_src1_addr = s1;
        bus.in_src2_addr = s2;
        bus.in_dst_addr  = d;
        bus.in_dst_we    = we;
        step();
        bus.in_valid = 1'b0;
        last_dst = d;
        last_we  = we;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!bus.out_valid && n < 20) begin
            step();
            n++;
        end
    endtask

    task automatic handshake();
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        if (last_we) m_busy[last_dst] = 1'b1;
    endtask

    task automatic handshake_wb(input logic [4:0] a, input logic [15:0] d);
        bus.out_ready = 1'b1;
        bus.wb_valid  = 1'b1;
        bus.wb_addr   = a;
        bus.wb_data   = d;
        step();
        bus.out_ready = 1'b0;
        bus.wb_valid  = 1'b0;
        m_mem[a]  = d;
        m_busy[a] = 1'b0;
        if (last_we) m_busy[last_dst] = 1'b1;
    endtask

    task automatic check_latency(input string name, input int n);
        nchecks++;
        if (n !== 3) begin
            nerr++;
            $display("FAIL %s latency got %0d want 3", name, n);
        end
    endtask

    task automatic check_ops(input string name, input logic [15:0] e1, input logic [15:0] e2);
        nchecks++;
        if (bus.out_src1 !== e1 || bus.out_src2 !== e2) begin
            nerr++;
            $display("FAIL %s operands got %h/%h want %h/%h", name, bus.out_src1, bus.out_src2, e1, e2);
        end
    endtask

    task automatic check_busy(input string name);
        nchecks++;
        if (dut.busy_q !== m_busy) begin
            nerr++;
            $display("FAIL %s busy got %h want %h", name, dut.busy_q, m_busy);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.wb_valid = 1'b1;
        bus.wb_addr  = 5'd0;
        bus.wb_data  = 16'hDEAD;
        step();
        step();
        nchecks++;
        if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0 || bus.rf_write !== 1'b0) begin
            nerr++;
            $display("FAIL reset_outputs in_ready=%0b out_valid=%0b rf_write=%0b want 0/0/0", bus.in_ready, bus.out_valid, bus.rf_write);
        end
        check_busy("reset");
        check_ops("reset", 16'h0, 16'h0);
        bus.wb_valid = 1'b0;
        rst_n = 1'b1;
        step();
        nchecks++;
        if (bus.in_ready !== 1'b1 || bus.rf_src1_addr !== 5'd0 || bus.out_dst_we !== 1'b0) begin
            nerr++;
            $display("FAIL reset_release in_ready=%0b rf_src1_addr=%0d dst_we=%0b want 1/0/0", bus.in_ready, bus.rf_src1_addr, bus.out_dst_we);
        end
    endtask

    task automatic preload();
        for (int i = 0; i < 32; i++) wb(5'(i), 16'($urandom));
    endtask

    task automatic test_basic();
        int n;
        wb(5'd3, 16'h1111);
        wb(5'd4, 16'h2222);
        issue(5'd3, 5'd4, 5'd5, 1'b1);
        wait_valid(n);
        check_latency("basic", n);
        check_ops("basic", 16'h1111, 16'h2222);
        nchecks++;
        if (bus.out_dst_addr !== 5'd5 || bus.out_dst_we !== 1'b1) begin
            nerr++;
            $display("FAIL basic_dst got %0d/%0b want 5/1", bus.out_dst_addr, bus.out_dst_we);
        end
        handshake();
        check_busy("basic");
        nchecks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            nerr++;
            $display("FAIL basic_idle in_ready=%0b out_valid=%0b want 1/0", bus.in_ready, bus.out_valid);
        end
    endtask

    task automatic test_raw();
        int n;
        issue(5'd10, 5'd11, 5'd7, 1'b1);
        wait_valid(n);
        handshake();
        issue(5'd7, 5'd12, 5'd13, 1'b0);
        repeat (4) step();
        nchecks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0) begin
            nerr++;
            $display("FAIL raw_stall out_valid=%0b in_ready=%0b want 0/0", bus.out_valid, bus.in_ready);
        end
        wb(5'd7, 16'hBEEF);
        wait_valid(n);
        check_latency("raw", n);
        check_ops("raw", 16'hBEEF, m_mem[12]);
        check_busy("raw");
        handshake();
    endtask

    task automatic test_waw();
        int n;
        issue(5'd14, 5'd15, 5'd9, 1'b1);
        wait_valid(n);
        handshake();
        issue(5'd16, 5'd17, 5'd9, 1'b1);
        repeat (5) step();
        nchecks++;
        if (bus.out_valid !== 1'b0) begin
            nerr++;
            $display("FAIL waw_stall out_valid=%0b want 0", bus.out_valid);
        end
        wb(5'd9, 16'h0909);
        wait_valid(n);
        check_latency("waw", n);
        check_ops("waw", m_mem[16], m_mem[17]);
        handshake();
        check_busy("waw");
        wb(5'd9, 16'h9999);
        wb(5'd5, 16'h5555);
    endtask

    task automatic test_backpressure();
        int n;
        logic [15:0] e1, e2;
        e1 = m_mem[3];
        e2 = m_mem[4];
        issue(5'd3, 5'd4, 5'd20, 1'b0);
        wait_valid(n);
        for (int i = 0; i < 6; i++) begin
            wb(5'd3, 16'($urandom));
            nchecks++;
            if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.out_src1 !== e1 || bus.out_src2 !== e2) begin
                nerr++;
                $display("FAIL backpressure cycle %0d valid=%0b ready=%0b src1=%h want 1/0/%h", i, bus.out_valid, bus.in_ready, bus.out_src1, e1);
            end
        end
        handshake();
        nchecks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            nerr++;
            $display("FAIL backpressure_release in_ready=%0b out_valid=%0b want 1/0", bus.in_ready, bus.out_valid);
        end
    endtask

    task automatic test_same_edge();
        int n;
        issue(5'd21, 5'd22, 5'd2, 1'b1);
        wait_valid(n);
        handshake_wb(5'd2, 16'h2020);
        nchecks++;
        if (dut.busy_q[2] !== 1'b1) begin
            nerr++;
            $display("FAIL same_edge_same busy[2]=%0b want 1", dut.busy_q[2]);
        end
        issue(5'd21, 5'd22, 5'd6, 1'b1);
        wait_valid(n);
        handshake();
        wb(5'd2, 16'h0202);
        issue(5'd21, 5'd22, 5'd2, 1'b1);
        wait_valid(n);
        check_latency("same_edge", n);
        handshake_wb(5'd6, 16'h0606);
        check_busy("same_edge_diff");
    endtask

    task automatic test_reset_midop();
        int n;
        issue(5'd23, 5'd24, 5'd1, 1'b1);
        wait_valid(n);
        handshake();
        issue(5'd1, 5'd25, 5'd26, 1'b0);
        step();
        rst_n = 1'b0;
        bus.wb_valid = 1'b1;
        bus.wb_addr  = 5'd1;
        bus.wb_data  = 16'hFFFF;
        #1;
        nchecks++;
        if (bus.rf_write !== 1'b0) begin
            nerr++;
            $display("FAIL midop_rf_write got %0b want 0", bus.rf_write);
        end
        step();
        m_busy = '0;
        nchecks++;
        if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0 || bus.rf_write !== 1'b0) begin
            nerr++;
            $display("FAIL midop_reset in_ready=%0b out_valid=%0b rf_write=%0b want 0/0/0", bus.in_ready, bus.out_valid, bus.rf_write);
        end
        check_busy("midop");
        check_ops("midop", 16'h0, 16'h0);
        bus.wb_valid = 1'b0;
        rst_n = 1'b1;
        step();
        nchecks++;
        if (bus.in_ready !== 1'b1) begin
            nerr++;
            $display("FAIL midop_idle in_ready=%0b want 1", bus.in_ready);
        end
        issue(5'd1, 5'd25, 5'd27, 1'b0);
        wait_valid(n);
        check_latency("midop_after", n);
        check_ops("midop_after", m_mem[1], m_mem[25]);
        handshake();
    endtask

    task automatic test_random();
        int n, k;
        logic [4:0] s1, s2, d;
        logic we, haz;
        for (int it = 0; it < 40; it++) begin
            if ($urandom_range(0, 1) == 1) wb(5'($urandom), 16'($urandom));
            s1 = 5'($urandom);
            s2 = 5'($urandom);
            d  = 5'($urandom);
            we = 1'($urandom);
            haz = m_busy[s1] | m_busy[s2] | (we & m_busy[d]);
            issue(s1, s2, d, we);
            if (haz) begin
                repeat (2) step();
                nchecks++;
                if (bus.out_valid !== 1'b0) begin
                    nerr++;
                    $display("FAIL rand_stall it=%0d out_valid=%0b want 0", it, bus.out_valid);
                end
                if (m_busy[s1]) wb(s1, 16'($urandom));
                if (m_busy[s2]) wb(s2, 16'($urandom));
                if (we && m_busy[d]) wb(d, 16'($urandom));
            end
            wait_valid(n);
            check_latency("rand", n);
            check_ops("rand", m_mem[s1], m_mem[s2]);
            nchecks++;
            if (bus.out_dst_addr !== d || bus.out_dst_we !== we) begin
                nerr++;
                $display("FAIL rand_dst it=%0d got %0d/%0b want %0d/%0b", it, bus.out_dst_addr, bus.out_dst_we, d, we);
            end
            k = $urandom_range(0, 3);
            repeat (k) step();
            nchecks++;
            if (bus.out_valid !== 1'b1 || bus.out_src1 !== m_mem[s1]) begin
                nerr++;
                $display("FAIL rand_hold it=%0d valid=%0b src1=%h want 1/%h", it, bus.out_valid, bus.out_src1, m_mem[s1]);
            end
            handshake();
            check_busy("rand");
        end
    endtask

    initial begin
        bus.in_valid     = 1'b0;
        bus.in_src1_addr = '0;
        bus.in_src2_addr = '0;
        bus.in_dst_addr  = '0;
        bus.in_dst_we    = 1'b0;
        bus.out_ready    = 1'b0;
        bus.wb_valid     = 1'b0;
        bus.wb_addr      = '0;
        bus.wb_data      = '0;
        test_reset();
        preload();
        test_basic();
        test_raw();
        test_waw();
        test_backpressure();
        test_same_edge();
        test_reset_midop();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
        $finish;
    end
endmodule
